// File: rtl/user_pattern_checker_if.sv
// Bundles the sample stream, pattern programming and checker status of user_pattern_checker.
// USER_PATTERN_ERR_CAPTURE_EN adds the first-error capture outputs.
interface user_pattern_checker_if #(
    parameter int DATA_W = 14,
    parameter int ERR_W  = 16
);
    logic              enable;
    logic              clear_err;
    logic [DATA_W-1:0] sample;
    logic              sample_valid;
    logic [15:0]       user_test_pattern1;
    logic [15:0]       user_test_pattern2;
    logic [15:0]       user_test_pattern3;
    logic [15:0]       user_test_pattern4;
    logic              locked;
    logic              err_flag;
    logic [ERR_W-1:0]  err_count;
    logic [1:0]        pattern_idx;
    logic [DATA_W-1:0] expected;
`ifdef USER_PATTERN_ERR_CAPTURE_EN
    logic [DATA_W-1:0] first_err_sample;
    logic [DATA_W-1:0] first_err_expected;
`endif

    modport master (
        output enable, clear_err, sample, sample_valid,
        output user_test_pattern1, user_test_pattern2, user_test_pattern3, user_test_pattern4,
        input  locked, err_flag, err_count, pattern_idx, expected
`ifdef USER_PATTERN_ERR_CAPTURE_EN
        , input first_err_sample, first_err_expected
`endif
    );

    modport slave (
        input  enable, clear_err, sample, sample_valid,
        input  user_test_pattern1, user_test_pattern2, user_test_pattern3, user_test_pattern4,
        output locked, err_flag, err_count, pattern_idx, expected
`ifdef USER_PATTERN_ERR_CAPTURE_EN
        , output first_err_sample, first_err_expected
`endif
    );
endinterface

// File: rtl/user_pattern_checker.sv
// Locks onto the repeating AD9643 user test pattern sequence P1..P4 and counts mismatches once locked.
// Define USER_PATTERN_ERR_CAPTURE_EN to latch the first counted mismatch and its expected value.
module user_pattern_checker #(
    parameter int DATA_W   = 14,
    parameter int ERR_W    = 16,
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    user_pattern_checker_if.slave  bus
);
    localparam int MC_W = $clog2(LOCK_CNT + 1);
    localparam int MS_W = $clog2(LOSS_CNT + 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {IDLE, SEARCH, VERIFY, LOCKED} state_t;

    state_t                   state_q, state_n;
    logic [3:0][DATA_W-1:0]   pat_q, pat_n, pat_in;
    logic [1:0]               idx_q, idx_n;
    logic [MC_W-1:0]          match_q, match_n;
    logic [MS_W-1:0]          miss_q, miss_n;
    logic [ERR_W-1:0]         err_cnt_q, err_cnt_n;
    logic                     err_flag_q, err_flag_n;
    logic [DATA_W-1:0]        expected_q, expected_n;
    logic                     hit, hit_first;
`ifdef USER_PATTERN_ERR_CAPTURE_EN
    logic [DATA_W-1:0]        fe_sample_q, fe_sample_n;
    logic [DATA_W-1:0]        fe_expected_q, fe_expected_n;
`endif

    // Patterns are MSB-justified 16-bit words; only the top DATA_W bits reach the sample bus.
    assign pat_in = {bus.user_test_pattern4[15:16-DATA_W], bus.user_test_pattern3[15:16-DATA_W],
                     bus.user_test_pattern2[15:16-DATA_W], bus.user_test_pattern1[15:16-DATA_W]};

    assign hit       = (bus.sample == pat_q[idx_q]);
    assign hit_first = (bus.sample == pat_q[0]);

    always_comb begin
        state_n    = state_q;
        pat_n      = pat_q;
        idx_n      = idx_q;
        match_n    = match_q;
        miss_n     = miss_q;
        err_cnt_n  = err_cnt_q;
        err_flag_n = err_flag_q;
`ifdef USER_PATTERN_ERR_CAPTURE_EN
        fe_sample_n   = fe_sample_q;
        fe_expected_n = fe_expected_q;
`endif
        if (!bus.enable) begin
            state_n = IDLE;
            idx_n   = 2'd0;
            match_n = '0;
            miss_n  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_n = SEARCH;
                    pat_n   = pat_in;
                    idx_n   = 2'd0;
                end
                SEARCH: begin
                    if (bus.sample_valid && hit_first) begin
                        idx_n   = 2'd1;
                        match_n = MC_W'(1);
                        if (LOCK_CNT == 1) begin
                            state_n = LOCKED;
                            match_n = '0;
                            miss_n  = '0;
                        end else begin
                            state_n = VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    if (bus.sample_valid) begin
                        if (hit) begin
                            idx_n   = idx_q + 2'd1;
                            match_n = match_q + MC_W'(1);
                            if (match_q == MC_W'(LOCK_CNT - 1)) begin
                                state_n = LOCKED;
                                match_n = '0;
                                miss_n  = '0;
                            end
                        end else if (hit_first) begin
                            // An out-of-order P1 restarts the run rather than dropping back to SEARCH.
                            idx_n   = 2'd1;
                            match_n = MC_W'(1);
                        end else begin
                            state_n = SEARCH;
                            pat_n   = pat_in;
                            idx_n   = 2'd0;
                            match_n = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (bus.sample_valid) begin
                        idx_n = idx_q + 2'd1;
                        if (hit) begin
                            miss_n = '0;
                        end else begin
                            if (err_cnt_q != ERR_MAX) err_cnt_n = err_cnt_q + ERR_W'(1);
                            err_flag_n = 1'b1;
`ifdef USER_PATTERN_ERR_CAPTURE_EN
                            if (!err_flag_q) begin
                                fe_sample_n   = bus.sample;
                                fe_expected_n = pat_q[idx_q];
                            end
`endif
                            if (miss_q == MS_W'(LOSS_CNT - 1)) begin
                                state_n = SEARCH;
                                pat_n   = pat_in;
                                idx_n   = 2'd0;
                                miss_n  = '0;
                            end else begin
                                miss_n = miss_q + MS_W'(1);
                            end
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        // Clear wins over a coincident mismatch, so that error is never counted.
        if (bus.clear_err) begin
            err_cnt_n  = '0;
            err_flag_n = 1'b0;
`ifdef USER_PATTERN_ERR_CAPTURE_EN
            fe_sample_n   = '0;
            fe_expected_n = '0;
`endif
        end
        expected_n = pat_n[idx_n];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pat_q      <= '0;
            idx_q      <= 2'd0;
            match_q    <= '0;
            miss_q     <= '0;
            err_cnt_q  <= '0;
            err_flag_q <= 1'b0;
            expected_q <= '0;
`ifdef USER_PATTERN_ERR_CAPTURE_EN
            fe_sample_q   <= '0;
            fe_expected_q <= '0;
`endif
        end else begin
            state_q    <= state_n;
            pat_q      <= pat_n;
            idx_q      <= idx_n;
            match_q    <= match_n;
            miss_q     <= miss_n;
            err_cnt_q  <= err_cnt_n;
            err_flag_q <= err_flag_n;
            expected_q <= expected_n;
`ifdef USER_PATTERN_ERR_CAPTURE_EN
            fe_sample_q   <= fe_sample_n;
            fe_expected_q <= fe_expected_n;
`endif
        end
    end

    assign bus.locked      = (state_q == LOCKED);
    assign bus.err_flag    = err_flag_q;
    assign bus.err_count   = err_cnt_q;
    assign bus.pattern_idx = idx_q;
    assign bus.expected    = expected_q;
`ifdef USER_PATTERN_ERR_CAPTURE_EN
    assign bus.first_err_sample   = fe_sample_q;
    assign bus.first_err_expected = fe_expected_q;
`endif
endmodule

// File: tb/tb_user_pattern_checker.sv
// Self-checking bench for user_pattern_checker: directed steps plus a randomized stream,
// compared every cycle against a sequence-level reference model.
module tb_user_pattern_checker;
    localparam int DATA_W   = 14;
    localparam int ERR_W    = 5;
    localparam int LOCK_CNT = 8;
    localparam int LOSS_CNT = 4;
    localparam int ERR_MAX  = (1 << ERR_W) - 1;
    localparam int SHIFT    = 16 - DATA_W;

    logic clk;
    logic rst_n;

    user_pattern_checker_if #(.DATA_W(DATA_W), .ERR_W(ERR_W)) bus ();

    user_pattern_checker #(
        .DATA_W(DATA_W), .ERR_W(ERR_W), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] pat_word [4];
    int          sp = 0;

    // Reference model: tracks the length of the current in-order run from P1 and the lock status.
    bit m_active, m_locked, m_flag;
    int m_pat [4];
    int m_run, m_idx, m_miss, m_err, m_fe_sample, m_fe_expected;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_locked = 0; m_flag = 0;
        m_run = 0; m_idx = 0; m_miss = 0; m_err = 0;
        m_fe_sample = 0; m_fe_expected = 0;
        for (int k = 0; k < 4; k++) m_pat[k] = 0;
    endtask

    task automatic model_capture();
        for (int k = 0; k < 4; k++) m_pat[k] = int'(pat_word[k]) >> SHIFT;
    endtask

    task automatic model_step(input bit en, input bit clr, input bit vld, input int smp);
        if (!en) begin
            m_active = 0; m_run = 0; m_locked = 0; m_miss = 0; m_idx = 0;
        end else if (!m_active) begin
            m_active = 1;
            model_capture();
            m_idx = 0;
        end else if (vld) begin
            if (m_locked) begin
                if (smp != m_pat[m_idx]) begin
                    if (!m_flag) begin
                        m_fe_sample   = smp;
                        m_fe_expected = m_pat[m_idx];
                    end
                    if (m_err < ERR_MAX) m_err++;
                    m_flag = 1;
                    m_miss++;
                end else begin
                    m_miss = 0;
                end
                m_idx = (m_idx + 1) % 4;
                if (m_miss == LOSS_CNT) begin
                    m_locked = 0; m_miss = 0; m_run = 0; m_idx = 0;
                    model_capture();
                end
            end else begin
                if (m_run > 0 && smp == m_pat[m_run % 4]) begin
                    m_run++;
                end else if (smp == m_pat[0]) begin
                    m_run = 1;
                end else begin
                    if (m_run > 0) model_capture();
                    m_run = 0;
                end
                m_idx = m_run % 4;
                if (m_run == LOCK_CNT) begin
                    m_locked = 1; m_miss = 0; m_run = 0;
                end
            end
        end
        if (clr) begin
            m_err = 0; m_flag = 0; m_fe_sample = 0; m_fe_expected = 0;
        end
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, ".locked"},      32'(bus.locked),      32'(m_locked));
        chk({tag, ".err_flag"},    32'(bus.err_flag),    32'(m_flag));
        chk({tag, ".err_count"},   32'(bus.err_count),   32'(m_err));
        chk({tag, ".pattern_idx"}, 32'(bus.pattern_idx), 32'(m_idx));
        chk({tag, ".expected"},    32'(bus.expected),    32'(m_pat[m_idx]));
`ifdef USER_PATTERN_ERR_CAPTURE_EN
        chk({tag, ".first_err_sample"},   32'(bus.first_err_sample),   32'(m_fe_sample));
        chk({tag, ".first_err_expected"}, 32'(bus.first_err_expected), 32'(m_fe_expected));
`endif
    endtask

    task automatic set_patterns(input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] c, input logic [15:0] d);
        pat_word[0] = a; pat_word[1] = b; pat_word[2] = c; pat_word[3] = d;
        bus.user_test_pattern1 = a;
        bus.user_test_pattern2 = b;
        bus.user_test_pattern3 = c;
        bus.user_test_pattern4 = d;
    endtask

    task automatic applyStimulus(input string tag, input bit en, input bit clr,
                                 input bit vld, input int smp);
        bus.enable       = en;
        bus.clear_err    = clr;
        bus.sample_valid = vld;
        bus.sample       = DATA_W'(smp);
        model_step(en, clr, vld, smp);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    function automatic int stream_value(input int pos);
        return int'(pat_word[pos]) >> SHIFT;
    endfunction

    task automatic send_clean(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(tag, 1'b1, 1'b0, 1'b1, stream_value(sp));
            sp = (sp + 1) % 4;
        end
    endtask

    task automatic send_bad(input string tag, input int value, input bit clr);
        applyStimulus(tag, 1'b1, clr, 1'b1, value);
        sp = (sp + 1) % 4;
    endtask

    initial begin
        $display("[TB] user_pattern_checker bench start");
        rst_n = 1'b0;
        bus.enable = 1'b0; bus.clear_err = 1'b0; bus.sample_valid = 1'b0; bus.sample = '0;
        set_patterns(16'h1110, 16'h2220, 16'h3330, 16'h4440);
        model_reset();
        #3;
        checkOutput("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Enter SEARCH, then stream starting at P3: P3/P4 ignored, lock after 8 in-order samples.
        applyStimulus("idle_exit", 1'b1, 1'b0, 1'b0, 0);
        sp = 2;
        send_clean("acquire", 2 + LOCK_CNT - 1);
        chk("pre_lock", 32'(bus.locked), 32'd0);
        send_clean("acquire", 1);
        chk("lock_reached", 32'(bus.locked), 32'd1);
        chk("lock_err_zero", 32'(bus.err_count), 32'd0);

        // One corrupted sample in place of P2.
        send_clean("locked", 1);
        send_bad("corrupt_p2", 0, 1'b0);
        chk("corrupt_count", 32'(bus.err_count), 32'd1);
        chk("corrupt_idx", 32'(bus.pattern_idx), 32'd2);
        chk("corrupt_expected", 32'(bus.expected), 32'(16'h3330 >> SHIFT));
        chk("corrupt_still_locked", 32'(bus.locked), 32'd1);
        send_clean("locked", 6);

        // Constant zero stream drops lock after LOSS_CNT misses.
        for (int i = 0; i < LOSS_CNT; i++) send_bad("zero_stream", 0, 1'b0);
        chk("loss_unlocked", 32'(bus.locked), 32'd0);
        chk("loss_count", 32'(bus.err_count), 32'(1 + LOSS_CNT));
        chk("loss_idx", 32'(bus.pattern_idx), 32'd0);

        // Three matches in VERIFY, then an out-of-order P1 restarts the run.
        sp = 0;
        send_clean("verify", 3);
        sp = 0;
        send_clean("verify_restart", 1);
        send_clean("verify_run", LOCK_CNT - 2);
        chk("restart_not_yet", 32'(bus.locked), 32'd0);
        send_clean("verify_run", 1);
        chk("restart_locked", 32'(bus.locked), 32'd1);
        chk("restart_no_err", 32'(bus.err_count), 32'(1 + LOSS_CNT));

        // Saturate the counter by alternating misses and matches so lock holds.
        for (int i = 0; i < ERR_MAX; i++) begin
            send_bad("saturate", 0, 1'b0);
            send_clean("saturate", 1);
        end
        chk("saturated", 32'(bus.err_count), 32'(ERR_MAX));
        send_bad("saturate_hold", 0, 1'b0);
        chk("saturate_hold", 32'(bus.err_count), 32'(ERR_MAX));
        send_clean("saturate", 1);
        send_bad("clear_vs_miss", 0, 1'b1);
        chk("clear_count", 32'(bus.err_count), 32'd0);
        chk("clear_flag", 32'(bus.err_flag), 32'd0);
        send_clean("post_clear", 4);

        // Asynchronous reset mid-LOCKED with valid toggling.
        for (int i = 0; i < 4; i++) begin
            applyStimulus("toggle", 1'b1, 1'b0, i[0], stream_value(sp));
            if (i[0]) sp = (sp + 1) % 4;
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checkOutput("async_reset");
        chk("async_reset_locked", 32'(bus.locked), 32'd0);
        #3;
        rst_n = 1'b1;
        applyStimulus("reacquire_idle", 1'b1, 1'b0, 1'b1, stream_value(sp));
        sp = 0;
        send_clean("reacquire", LOCK_CNT - 1);
        chk("reacquire_not_yet", 32'(bus.locked), 32'd0);
        send_clean("reacquire", 1);
        chk("reacquire_locked", 32'(bus.locked), 32'd1);
        send_bad("first_err", 'h0AB, 1'b0);
        send_clean("first_err", 1);
        send_bad("second_err", 'h155, 1'b0);
`ifdef USER_PATTERN_ERR_CAPTURE_EN
        chk("first_err_kept", 32'(bus.first_err_sample), 32'h0AB);
`endif
        chk("two_errors", 32'(bus.err_count), 32'd2);

        // Randomized stream with occasional disables, pattern changes, clears and corruption.
        for (int i = 0; i < 3000; i++) begin
            bit en, clr, vld, bad;
            int smp;
            en  = ($urandom_range(0, 99) >= 2);
            clr = ($urandom_range(0, 59) == 0);
            vld = ($urandom_range(0, 3) != 0);
            bad = ($urandom_range(0, 11) == 0);
            if (!en && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    logic [15:0] w;
                    w = 16'($urandom);
                    set_patterns(w, w, w, w);
                end else begin
                    set_patterns(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
                end
                sp = $urandom_range(0, 3);
            end
            smp = bad ? int'($urandom_range(0, (1 << DATA_W) - 1)) : stream_value(sp);
            applyStimulus("random", en, clr, vld, smp);
            if (vld) sp = (sp + 1) % 4;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
